// File: rtl/exec_ctrl_pkg.sv
// Shared CPU control definitions: execution FSM state codes and default halt opcode.
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        StHalted = 2'd0,
        StRun    = 2'd1,
        StStep   = 2'd2,
        StBreak  = 2'd3
    } exec_state_e;

    localparam int unsigned CNT_W_DEFAULT   = 16;
    localparam logic [6:0]  HALT_OP_DEFAULT = 7'h7F;

    function automatic logic is_stopped(exec_state_e s);
        return (s == StHalted) || (s == StBreak);
    endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Debug/control bus between the host (requests, breakpoint, datapath view) and exec_ctrl.
interface exec_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             run_req;
    logic             halt_req;
    logic             step_req;
    logic             bp_en;
    logic [7:0]       bp_addr;
    logic [7:0]       pc_in;
    logic [6:0]       opcode;
    logic             clr_cnt;

    logic             cpu_en;
    logic [1:0]       state;
    logic             halted;
    logic             bp_hit;
    logic             step_done;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output run_req, halt_req, step_req, bp_en, bp_addr, pc_in, opcode, clr_cnt,
        input  cpu_en, state, halted, bp_hit, step_done, instr_count
    );

    modport slave (
        input  run_req, halt_req, step_req, bp_en, bp_addr, pc_in, opcode, clr_cnt,
        output cpu_en, state, halted, bp_hit, step_done, instr_count
    );

endinterface

// File: rtl/exec_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_at_max;

    assign w_at_max = (r_count == {WIDTH{1'b1}});

    always_comb begin
        w_count_nxt = r_count;
        if (clr) begin
            w_count_nxt = '0;
        end else if (inc && !w_at_max) begin
            w_count_nxt = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/exec_ctrl.sv
// Execution controller: run/halt/step/breakpoint FSM gating the datapath, plus an
// executed-instruction counter.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter logic [6:0]  HALT_OP = HALT_OP_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    exec_ctrl_if.slave   bus
);

    exec_state_e      r_state;
    exec_state_e      w_state_nxt;
    logic             r_skip_bp;
    logic             w_skip_bp_nxt;
    logic             r_step_done;
    logic             w_step_done_nxt;

    logic             w_bp_match;
    logic             w_halt_op;
    logic             w_exec;
    logic             w_cpu_en;
    logic [CNT_W-1:0] w_count;

    assign w_bp_match = bus.bp_en && (bus.pc_in == bus.bp_addr) && !r_skip_bp;
    assign w_halt_op  = (bus.opcode == HALT_OP);

    always_comb begin
        w_state_nxt     = r_state;
        w_skip_bp_nxt   = 1'b0;
        w_step_done_nxt = 1'b0;
        w_exec          = 1'b0;

        unique case (r_state)
            StHalted: begin
                if (bus.halt_req) begin
                    w_state_nxt = StHalted;
                end else if (bus.step_req) begin
                    w_state_nxt = StStep;
                end else if (bus.run_req) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                w_exec = !bus.halt_req && !w_bp_match && !w_halt_op;
                // Any non-executing RUN cycle leaves RUN, so the skip flag only survives stalls
                // that never happen; clearing on the first executed instruction is enough.
                w_skip_bp_nxt = r_skip_bp && !w_exec;
                if (bus.halt_req || w_halt_op) begin
                    w_state_nxt = StHalted;
                end else if (w_bp_match) begin
                    w_state_nxt = StBreak;
                end
            end
            StStep: begin
                w_exec          = !bus.halt_req && !w_halt_op;
                w_step_done_nxt = !bus.halt_req;
                w_state_nxt     = StHalted;
            end
            StBreak: begin
                if (bus.halt_req) begin
                    w_state_nxt = StHalted;
                end else if (bus.step_req) begin
                    w_state_nxt = StStep;
                end else if (bus.run_req) begin
                    w_state_nxt   = StRun;
                    w_skip_bp_nxt = 1'b1;
                end
            end
        endcase
    end

    // Reset masks the enable combinationally so the datapath freezes before any edge.
    assign w_cpu_en = w_exec && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StHalted;
            r_skip_bp   <= 1'b0;
            r_step_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_skip_bp   <= w_skip_bp_nxt;
            r_step_done <= w_step_done_nxt;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.clr_cnt),
        .inc   (w_cpu_en),
        .count (w_count)
    );

    assign bus.cpu_en      = w_cpu_en;
    assign bus.state       = r_state;
    assign bus.halted      = is_stopped(r_state);
    assign bus.bp_hit      = (r_state == StBreak);
    assign bus.step_done   = r_step_done;
    assign bus.instr_count = w_count;

endmodule
